mem_port_ctrl: RTL and testbench

Single-port initiator for the 16-entry register-file memory. Accepts read/write requests from the core over a valid/ready handshake, drives the memory's `address`/`din`/`load_mem`/`memory_out_en` pins with the required one-cycle strobes, and returns read data through a registered response port. It also provides a hardware zeroize sweep that writes 0 to all 16 words for secure wipe. Sits between the execution unit and the memory instance.

---
 rtl/mem_port_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_port_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: single-port initiator for the 16-word register-file memory.
// Serves core read/write requests and runs a hardware zeroize sweep.
module mem_port_ctrl #(
   parameter int data_size = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [3:0]           req_addr,
   input  logic [data_size-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic [data_size-1:0] rsp_data,
   input  logic                 zeroize_req,
   output logic                 zeroize_busy,
   output logic                 zeroize_done,
   output logic [3:0]           mem_address,
   output logic [data_size-1:0] mem_din,
   output logic                 mem_load,
   output logic                 mem_out_en,
   input  logic [data_size-1:0] mem_dout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_ZERO
   } state_t;

   state_t               r_state, w_state;
   logic                 r_ready, w_ready;
   logic [3:0]           r_cnt, w_cnt;
   logic [3:0]           r_addr, w_addr;
   logic [data_size-1:0] r_din, w_din;
   logic                 r_load, w_load;
   logic                 r_oen, w_oen;
   logic                 r_rsp_v, w_rsp_v;
   logic [data_size-1:0] r_rsp_d, w_rsp_d;
   logic                 r_busy, w_busy;
   logic                 r_done, w_done;
   logic                 w_accept;

   // A pending zeroize masks ready so a request is never handshaken
   // in the same cycle the sweep wins arbitration.
   assign req_ready = r_ready & ~zeroize_req;
   assign w_accept  = req_valid & req_ready;

   assign rsp_valid    = r_rsp_v;
   assign rsp_data     = r_rsp_d;
   assign zeroize_busy = r_busy;
   assign zeroize_done = r_done;
   assign mem_address  = r_addr;
   assign mem_din      = r_din;
   assign mem_load     = r_load;
   assign mem_out_en   = r_oen;

   // Next-state and next registered-output values.
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_addr  = '0;
      w_din   = '0;
      w_load  = 1'b0;
      w_oen   = 1'b0;
      w_rsp_v = 1'b0;
      w_rsp_d = r_rsp_d;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (zeroize_req) begin
               w_state = S_ZERO;
               w_cnt   = 4'd0;
               w_load  = 1'b1;
               w_busy  = 1'b1;
            end else if (w_accept) begin
               w_addr = req_addr;
               if (req_write) begin
                  w_state = S_WRITE;
                  w_din   = req_wdata;
                  w_load  = 1'b1;
               end else begin
                  w_state = S_READ;
                  w_oen   = 1'b1;
               end
            end
         end
         S_WRITE: begin
            w_state = S_IDLE;
            w_rsp_v = 1'b1;
            w_rsp_d = '0;
         end
         S_READ: begin
            w_state = S_IDLE;
            w_rsp_v = 1'b1;
            w_rsp_d = mem_dout;
         end
         S_ZERO: begin
            if (r_cnt == 4'hF) begin
               w_state = S_IDLE;
               w_done  = 1'b1;
            end else begin
               w_cnt  = r_cnt + 4'd1;
               w_addr = r_cnt + 4'd1;
               w_load = 1'b1;
               w_busy = 1'b1;
            end
         end
      endcase
      w_ready = (w_state == S_IDLE);
   end

   // State and output registers; reset aborts any in-flight strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_din   <= '0;
         r_load  <= 1'b0;
         r_oen   <= 1'b0;
         r_rsp_v <= 1'b0;
         r_rsp_d <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_ready <= w_ready;
         r_cnt   <= w_cnt;
         r_addr  <= w_addr;
         r_din   <= w_din;
         r_load  <= w_load;
         r_oen   <= w_oen;
         r_rsp_v <= w_rsp_v;
         r_rsp_d <= w_rsp_d;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: scoreboard bench for mem_port_ctrl with a behavioural
// memory instance and a word-level reference model of memory contents.
module tb_mem_port_ctrl;

   localparam int DW = 32;

   typedef struct {
      bit          w;
      logic [3:0]  a;
      logic [31:0] d;
      int          cyc;
   } rq_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [3:0]    req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          zeroize_req;
   logic          zeroize_busy;
   logic          zeroize_done;
   logic [3:0]    mem_address;
   logic [DW-1:0] mem_din;
   logic          mem_load;
   logic          mem_out_en;
   logic [DW-1:0] mem_dout;

   mem_port_ctrl #(.data_size(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .zeroize_req  (zeroize_req),
      .zeroize_busy (zeroize_busy),
      .zeroize_done (zeroize_done),
      .mem_address  (mem_address),
      .mem_din      (mem_din),
      .mem_load     (mem_load),
      .mem_out_en   (mem_out_en),
      .mem_dout     (mem_dout)
   );

   always #5 clk = ~clk;

   // Memory instance: synchronous write, combinational gated read.
   logic [DW-1:0] mem_arr [16];
   always @(posedge clk) if (mem_load) mem_arr[mem_address] <= mem_din;
   assign mem_dout = mem_out_en ? mem_arr[mem_address] : '0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ref_mem [16];
   rq_t         rsp_q [$];
   rq_t         st_q [$];
   int          zq [$];
   int          zcnt = 0;
   logic [31:0] exp_last = '0;
   rq_t         mon_e;
   rq_t         mon_s;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor: strobes, zeroize sweep and responses against the model.
   always @(negedge clk) begin
      if (!reset) begin
         rsp_q.delete();
         st_q.delete();
         zq.delete();
         zcnt = 0;
         exp_last = '0;
      end else begin
         if (mem_load || mem_out_en)
            check("no_overlap", 64'(mem_load & mem_out_en), 0);
         if (!mem_load && !mem_out_en) begin
            check("idle_addr", 64'(mem_address), 0);
            check("idle_din", 64'(mem_din), 0);
         end
         if ((mem_load && !zeroize_busy) || mem_out_en) begin
            if (st_q.size() == 0) check("unexpected_strobe", 1, 0);
            else begin
               mon_s = st_q.pop_front();
               check("strobe_kind", 64'(mem_load), 64'(mon_s.w));
               check("strobe_addr", 64'(mem_address), 64'(mon_s.a));
               if (mon_s.w) check("strobe_din", 64'(mem_din), 64'(mon_s.d));
            end
         end
         if (zeroize_busy) begin
            check("zero_addr", 64'(mem_address), 64'(zcnt));
            check("zero_load", 64'(mem_load), 1);
            check("zero_din", 64'(mem_din), 0);
            zcnt++;
         end
         if (zeroize_done) begin
            check("zero_len", 64'(zcnt), 16);
            if (zq.size() == 0) check("unexpected_done", 1, 0);
            else check("done_cycle", 64'(cyc), 64'(zq.pop_front()));
            zcnt = 0;
            for (int i = 0; i < 16; i++) ref_mem[i] = '0;
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) check("unexpected_rsp", 1, 0);
            else begin
               mon_e = rsp_q.pop_front();
               check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
               if (mon_e.w) begin
                  check("wr_rsp_data", 64'(rsp_data), 0);
                  ref_mem[mon_e.a] = mon_e.d;
                  exp_last = '0;
               end else begin
                  check("rd_rsp_data", 64'(rsp_data), 64'(ref_mem[mon_e.a]));
                  exp_last = ref_mem[mon_e.a];
               end
            end
         end else begin
            check("rsp_hold", 64'(rsp_data), 64'(exp_last));
         end
      end
   end

   task automatic do_req(input bit w, input logic [3:0] a,
                         input logic [31:0] d, output int acc,
                         output int waits);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      waits = 0;
      acc = -1;
      #1;
      while (!req_ready && waits < 64) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (!req_ready) begin
         check("req_timeout", 1, 0);
         req_valid = 1'b0;
      end else begin
         acc = cyc;
         rsp_q.push_back('{w, a, d, cyc + 2});
         st_q.push_back('{w, a, d, 0});
         @(posedge clk);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      req_valid = 1'b0;
      #2;
      while ((rsp_q.size() != 0 || zq.size() != 0) && n < 64) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("drain_pending", 64'(rsp_q.size() + zq.size()), 0);
   endtask

   task automatic start_zero(output int c);
      @(negedge clk);
      zeroize_req = 1'b1;
      #1;
      c = cyc;
      zq.push_back(c + 17);
      @(posedge clk);
      #1;
      zeroize_req = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req_ready"}, 64'(req_ready), 0);
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
      check({tag, "_rsp_data"}, 64'(rsp_data), 0);
      check({tag, "_busy"}, 64'(zeroize_busy), 0);
      check({tag, "_done"}, 64'(zeroize_done), 0);
      check({tag, "_addr"}, 64'(mem_address), 0);
      check({tag, "_din"}, 64'(mem_din), 0);
      check({tag, "_load"}, 64'(mem_load), 0);
      check({tag, "_out_en"}, 64'(mem_out_en), 0);
   endtask

   task automatic hit_reset(input string tag);
      reset = 1'b0;
      req_valid = 1'b0;
      zeroize_req = 1'b0;
      #1;
      check_zero(tag);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("ready_pre_clk", 64'(req_ready), 0);
      @(posedge clk);
      #1;
      check("ready_post_clk", 64'(req_ready), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, acc, w, op;
      reset = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      zeroize_req = 1'b0;
      hit_reset("reset_state");

      do_req(1'b1, 4'd5, 32'hDEADBEEF, acc, w);
      do_req(1'b0, 4'd5, 32'h0, acc, w);
      drain();

      for (int i = 0; i < 16; i++) begin
         do_req(1'b1, 4'(i), 32'(i) * 32'h11111111, acc, w);
         if (i > 0) check("b2b_wr_gap", 64'(w), 1);
      end
      for (int i = 15; i >= 0; i--) begin
         do_req(1'b0, 4'(i), 32'h0, acc, w);
         check("b2b_rd_gap", 64'(w), 1);
      end
      drain();

      for (int i = 0; i < 16; i++)
         do_req(1'b1, 4'(i), 32'hFFFFFFFF, acc, w);
      drain();
      start_zero(c);
      drain();
      for (int i = 0; i < 16; i++)
         do_req(1'b0, 4'(i), 32'h0, acc, w);
      drain();

      @(negedge clk);
      zeroize_req = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr = 4'd3;
      req_wdata = 32'hA5A50303;
      #1;
      check("zero_prio_ready", 64'(req_ready), 0);
      c = cyc;
      zq.push_back(c + 17);
      @(posedge clk);
      #1;
      zeroize_req = 1'b0;
      do_req(1'b1, 4'd3, 32'hA5A50303, acc, w);
      check("post_zero_accept", 64'(acc), 64'(c + 17));
      do_req(1'b0, 4'd3, 32'h0, acc, w);
      drain();

      do_req(1'b1, 4'd9, 32'h12345678, acc, w);
      #2;
      hit_reset("rst_write");
      drain();
      start_zero(c);
      repeat (7) @(posedge clk);
      #2;
      hit_reset("rst_zero");

      for (int i = 0; i < 16; i++)
         do_req(1'b1, 4'(i), $urandom, acc, w);
      for (int k = 0; k < 150; k++) begin
         op = int'($urandom_range(0, 24));
         if (op == 0) begin
            drain();
            start_zero(c);
            drain();
         end else begin
            do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   $urandom, acc, w);
            if ($urandom_range(0, 3) == 0) drain();
         end
      end
      drain();
      check("end_rsp_q", 64'(rsp_q.size()), 0);
      check("end_strobe_q", 64'(st_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
